// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for a shared combinational ALU.
// Sequences one operation at a time through IDLE -> EXEC -> RESP and holds the
// response until the consumer takes it.
// Optional build macro ALU_ARB_OPCHECK_EN: adds rsp_err and forces a zero result
// for opcodes the ALU does not implement.
module alu_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [3:0]        req0_opcode,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [4:0]        req0_shamt,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [3:0]        req1_opcode,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [4:0]        req1_shamt,
    output logic [3:0]        alu_opcode,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [4:0]        alu_shamt,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
`ifdef ALU_ARB_OPCHECK_EN
    output logic              rsp_err,
`endif
    output logic              busy,
    output logic [CNT_W-1:0]  ops_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   last_grant;
    logic   grant_id;
    logic   accept;

    // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        grant_id = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

    // Next state and handshake decode; ready is gated by rst_n so it stays low in reset.
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            IDLE: begin
                if (rst_n && (req0_valid || req1_valid)) begin
                    accept     = 1'b1;
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                    state_nxt  = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

`ifdef ALU_ARB_OPCHECK_EN
    logic op_illegal;

    // Flag opcodes outside the implemented ALU set.
    always_comb begin
        op_illegal = 1'b1;
        case (alu_opcode)
            4'd0, 4'd1, 4'd2, 4'd4, 4'd6, 4'd7, 4'd8: op_illegal = 1'b0;
            default: op_illegal = 1'b1;
        endcase
    end
`endif

    // Datapath: latch the granted operation, capture the ALU result, count handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_shamt  <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
            rsp_err    <= 1'b0;
`endif
            busy       <= 1'b0;
            ops_done   <= '0;
        end else begin
            busy <= (state_nxt != IDLE);
            if (accept) begin
                last_grant <= grant_id;
                rsp_id     <= grant_id;
                alu_opcode <= grant_id ? req1_opcode : req0_opcode;
                alu_a      <= grant_id ? req1_a      : req0_a;
                alu_b      <= grant_id ? req1_b      : req0_b;
                alu_shamt  <= grant_id ? req1_shamt  : req0_shamt;
            end
            if (state == EXEC) begin
                rsp_valid  <= 1'b1;
`ifdef ALU_ARB_OPCHECK_EN
                rsp_result <= op_illegal ? '0 : alu_out;
                rsp_zero   <= op_illegal | alu_zero;
                rsp_err    <= op_illegal;
`else
                rsp_result <= alu_out;
                rsp_zero   <= alu_zero;
`endif
            end
            if ((state == RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
                ops_done  <= ops_done + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic scored against
// a transaction-level model (round-robin pick, ALU arithmetic, handshake count).
module tb_alu_arbiter;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              v [2];
    logic [3:0]        op [2];
    logic [DATA_W-1:0] a [2];
    logic [DATA_W-1:0] b [2];
    logic [4:0]        sh [2];
    logic              rdy0, rdy1;
    logic [3:0]        alu_opcode;
    logic [DATA_W-1:0] alu_a, alu_b, alu_out;
    logic [4:0]        alu_shamt;
    logic              alu_zero;
    logic              rsp_valid, rsp_ready, rsp_id, rsp_zero, busy;
    logic [DATA_W-1:0] rsp_result;
    logic [CNT_W-1:0]  ops_done;
`ifdef ALU_ARB_OPCHECK_EN
    logic              rsp_err;
`endif

    int          n_cmp = 0;
    int          n_err = 0;
    int          last_w;
    int unsigned exp_ops;
    logic [DATA_W-1:0] got_res;
    logic              got_zero;
    logic              got_id;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v[0]), .req0_ready(rdy0), .req0_opcode(op[0]),
        .req0_a(a[0]), .req0_b(b[0]), .req0_shamt(sh[0]),
        .req1_valid(v[1]), .req1_ready(rdy1), .req1_opcode(op[1]),
        .req1_a(a[1]), .req1_b(b[1]), .req1_shamt(sh[1]),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt),
        .alu_out(alu_out), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
`ifdef ALU_ARB_OPCHECK_EN
        .rsp_err(rsp_err),
`endif
        .busy(busy), .ops_done(ops_done)
    );

    // Arithmetic of the shared ALU; unimplemented opcodes return a^b.
    function automatic logic [DATA_W-1:0] ref_alu(input logic [3:0] o, input logic [DATA_W-1:0] x,
                                                  input logic [DATA_W-1:0] y, input logic [4:0] s);
        case (o)
            4'd0:       return x & y;
            4'd1:       return x | y;
            4'd2, 4'd4: return x + y;
            4'd6:       return x - y;
            4'd7:       return ($signed(x) < $signed(y)) ? DATA_W'(1) : DATA_W'(0);
            4'd8:       return x << s;
            default:    return x ^ y;
        endcase
    endfunction

    function automatic logic is_legal(input logic [3:0] o);
        return o inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd6, 4'd7, 4'd8};
    endfunction

    function automatic logic [DATA_W-1:0] exp_result(input logic [3:0] o, input logic [DATA_W-1:0] x,
                                                     input logic [DATA_W-1:0] y, input logic [4:0] s);
`ifdef ALU_ARB_OPCHECK_EN
        if (!is_legal(o)) return '0;
`endif
        return ref_alu(o, x, y, s);
    endfunction

    // External ALU seen by the DUT.
    always_comb begin
        alu_out  = ref_alu(alu_opcode, alu_a, alu_b, alu_shamt);
        alu_zero = (alu_out == '0);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int n, input logic [3:0] o, input logic [DATA_W-1:0] x,
                           input logic [DATA_W-1:0] y, input logic [4:0] s);
        v[n] = 1'b1; op[n] = o; a[n] = x; b[n] = y; sh[n] = s;
    endtask

    function automatic logic [3:0] rand_op();
        int k;
        k = $urandom_range(0, 7);
        case (k)
            0: return 4'd0;
            1: return 4'd1;
            2: return 4'd2;
            3: return 4'd4;
            4: return 4'd6;
            5: return 4'd7;
            6: return 4'd8;
            default: return 4'($urandom_range(9, 15));
        endcase
    endfunction

    task automatic rand_req(input int n);
        logic [DATA_W-1:0] x, y;
        x = DATA_W'($urandom);
        y = ($urandom_range(0, 3) == 0) ? x : DATA_W'($urandom);
        set_req(n, rand_op(), x, y, 5'($urandom_range(0, 31)));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; v[0] = 1'b0; v[1] = 1'b0; rsp_ready = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b1;
        last_w = 1; exp_ops = 0;
    endtask

    // One full operation from IDLE: predicted grant, latency, hold, handshake.
    task automatic serve(input int hold, input bit bump);
        int w;
        logic [3:0] eo; logic [DATA_W-1:0] ea, eb, er; logic [4:0] es;
        #1;
        if (v[0] && v[1]) w = 1 - last_w;
        else if (v[1])    w = 1;
        else              w = 0;
        chk("req0_ready", 64'(rdy0), 64'(w == 0));
        chk("req1_ready", 64'(rdy1), 64'(w == 1));
        eo = op[w]; ea = a[w]; eb = b[w]; es = sh[w];
        er = exp_result(eo, ea, eb, es);
        last_w = w;
        rsp_ready = (hold == 0);
        @(negedge clk);
        v[w] = 1'b0;
        if (bump && !v[1-w]) rand_req(1 - w);
        #1;
        chk("exec_busy", 64'(busy), 64'(1));
        chk("exec_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("exec_ready", 64'({rdy1, rdy0}), 64'(0));
        chk("alu_opcode", 64'(alu_opcode), 64'(eo));
        chk("alu_a", 64'(alu_a), 64'(ea));
        chk("alu_b", 64'(alu_b), 64'(eb));
        chk("alu_shamt", 64'(alu_shamt), 64'(es));
        @(negedge clk); #1;
        got_res = rsp_result; got_zero = rsp_zero; got_id = rsp_id;
        chk("rsp_valid", 64'(rsp_valid), 64'(1));
        chk("rsp_id", 64'(rsp_id), 64'(w));
        chk("rsp_result", 64'(rsp_result), 64'(er));
        chk("rsp_zero", 64'(rsp_zero), 64'(er == '0));
`ifdef ALU_ARB_OPCHECK_EN
        chk("rsp_err", 64'(rsp_err), 64'(!is_legal(eo)));
`endif
        for (int i = 0; i < hold; i++) begin
            @(negedge clk); #1;
            chk("hold_valid", 64'(rsp_valid), 64'(1));
            chk("hold_result", 64'(rsp_result), 64'(er));
            chk("hold_id", 64'(rsp_id), 64'(w));
            chk("hold_ready", 64'({rdy1, rdy0}), 64'(0));
            chk("hold_alu_a", 64'(alu_a), 64'(ea));
        end
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        exp_ops = (exp_ops + 1) % (1 << CNT_W);
        chk("done_valid", 64'(rsp_valid), 64'(0));
        chk("ops_done", 64'(ops_done), 64'(exp_ops));
        chk("done_busy", 64'(busy), 64'(0));
        rsp_ready = 1'($urandom_range(0, 1));
    endtask

    // A cycle with no requests must not start anything.
    task automatic idle_step();
        v[0] = 1'b0; v[1] = 1'b0;
        #1;
        chk("idle_ready", 64'({rdy1, rdy0}), 64'(0));
        @(negedge clk); #1;
        chk("idle_busy", 64'(busy), 64'(0));
        chk("idle_rsp_valid", 64'(rsp_valid), 64'(0));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; rsp_ready = 1'b0; last_w = 1; exp_ops = 0;
        for (int n = 0; n < 2; n++) begin
            v[n] = 1'b0; op[n] = '0; a[n] = '0; b[n] = '0; sh[n] = '0;
        end
        v[0] = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready0", 64'(rdy0), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_id", 64'(rsp_id), 64'(0));
        chk("rst_rsp_result", 64'(rsp_result), 64'(0));
        chk("rst_rsp_zero", 64'(rsp_zero), 64'(0));
        chk("rst_alu", 64'({alu_opcode, alu_shamt}), 64'(0));
        chk("rst_alu_ab", 64'({alu_a, alu_b}), 64'(0));
        chk("rst_ops_done", 64'(ops_done), 64'(0));

        // Single ADD right out of reset.
        rst_n = 1'b1;
        set_req(0, 4'd2, 32'd10, 32'd15, 5'd0);
        serve(0, 1'b0);
        chk("add_result", 64'(got_res), 64'(25));
        chk("add_zero", 64'(got_zero), 64'(0));
        chk("add_id", 64'(got_id), 64'(0));
        chk("add_ops", 64'(ops_done), 64'(1));
        idle_step();

        // Simultaneous SUBs after reset: req0 first, then req1, third tie to req0.
        do_reset();
        set_req(0, 4'd6, 32'd20, 32'd10, 5'd0);
        set_req(1, 4'd6, 32'd10, 32'd10, 5'd0);
        serve(0, 1'b0);
        chk("tie1_id", 64'(got_id), 64'(0));
        chk("tie1_result", 64'(got_res), 64'(10));
        serve(0, 1'b0);
        chk("tie2_id", 64'(got_id), 64'(1));
        chk("tie2_result", 64'(got_res), 64'(0));
        chk("tie2_zero", 64'(got_zero), 64'(1));
        set_req(0, 4'd1, 32'h0000_00F0, 32'h0000_000F, 5'd0);
        set_req(1, 4'd0, 32'h0000_00F0, 32'h0000_000F, 5'd0);
        serve(0, 1'b0);
        chk("tie3_id", 64'(got_id), 64'(0));
        serve(0, 1'b0);

        // SLL held in RESP for five cycles while req0 waits.
        set_req(1, 4'd8, 32'd1, 32'd0, 5'd4);
        serve(5, 1'b1);
        chk("sll_result", 64'(got_res), 64'(16));
        chk("sll_id", 64'(got_id), 64'(1));
        serve(0, 1'b0);

        // Reset during EXEC aborts the operation.
        set_req(0, 4'd0, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd0);
        #1;
        chk("abort_ready0", 64'(rdy0), 64'(1));
        @(negedge clk);
        v[0] = 1'b0;
        #1;
        chk("abort_busy_pre", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("abort_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("abort_rsp", 64'({rsp_id, rsp_zero, rsp_result}), 64'(0));
        chk("abort_alu", 64'({alu_opcode, alu_shamt, alu_a}), 64'(0));
        chk("abort_alu_b", 64'(alu_b), 64'(0));
        chk("abort_ops", 64'(ops_done), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        @(negedge clk); #1;
        rst_n = 1'b1; last_w = 1; exp_ops = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("abort_no_rsp", 64'(rsp_valid), 64'(0));
            chk("abort_ops_after", 64'(ops_done), 64'(0));
        end

        // Unimplemented opcode.
        set_req(0, 4'd15, 32'd123, 32'd456, 5'd0);
        serve(0, 1'b0);
`ifdef ALU_ARB_OPCHECK_EN
        chk("illegal_result", 64'(got_res), 64'(0));
        chk("illegal_zero", 64'(got_zero), 64'(1));
`else
        chk("illegal_result", 64'(got_res), 64'(32'd123 ^ 32'd456));
`endif

        // Randomized traffic; ops_done must wrap after 2^CNT_W handshakes.
        do_reset();
        for (int k = 0; k < 48; k++) begin
            int pat;
            if (k == (1 << CNT_W)) chk("ops_wrap", 64'(ops_done), 64'(0));
            if ($urandom_range(0, 7) == 0) idle_step();
            pat = $urandom_range(1, 3);
            if (pat[0] && !v[0]) rand_req(0);
            if (pat[1] && !v[1]) rand_req(1);
            serve($urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
